// File: rtl/adv_ddr_pkg.sv
// Shared types and constants for the ADV7511-style DDR receive path.
package adv_ddr_pkg;

    // Default counter widths and the runt-line threshold.
    localparam int H_W_DEF       = 12;
    localparam int V_W_DEF       = 11;
    localparam int MIN_H_ACT_DEF = 16;

    // Width of one DDR half-pixel on the pins.
    localparam int HALF_W        = 12;

    // 720p active geometry, handy for benches and bring-up checks.
    localparam int H_ACT_720P    = 1280;
    localparam int V_ACT_720P    = 720;

    // Lock state machine.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } lock_state_e;

endpackage

// File: rtl/adv_ddr_rx_meas.sv
// Active-video measurement and lock tracking, driven purely by the
// reassembled pixel strobe with its DE and VSYNC.
module adv_ddr_rx_meas
    import adv_ddr_pkg::*;
#(
    parameter int H_W       = H_W_DEF,
    parameter int V_W       = V_W_DEF,
    parameter int MIN_H_ACT = MIN_H_ACT_DEF
) (
    input  logic           clk_in,
    input  logic           reset_n,
    input  logic           pix_vld,
    input  logic           de,
    input  logic           vs,
    output logic [H_W-1:0] h_active,
    output logic [V_W-1:0] v_active,
    output logic           locked
);

    localparam logic [H_W-1:0] MIN_W = H_W'(MIN_H_ACT);

    logic           de_prev_q, de_prev_d;
    logic           vs_prev_q, vs_prev_d;
    logic [H_W-1:0] px_cnt_q, px_cnt_d;
    logic [V_W-1:0] line_cnt_q, line_cnt_d;
    logic [H_W-1:0] width_q, width_d;

    logic [H_W-1:0] ref_w_q;
    logic [V_W-1:0] ref_l_q;
    logic [H_W-1:0] h_act_q;
    logic [V_W-1:0] v_act_q;
    logic           locked_q;
    lock_state_e    state_q;

    logic           de_fall;
    logic           vs_fall;
    logic           line_ok;
    logic [H_W-1:0] width_eff;
    logic [V_W-1:0] lines_eff;
    logic           frame_match;

    // Edge detection and line/pixel counting. A line landing on the same
    // pixel as the frame boundary is folded into that frame via *_eff.
    always_comb begin
        de_prev_d  = de_prev_q;
        vs_prev_d  = vs_prev_q;
        px_cnt_d   = px_cnt_q;
        de_fall    = pix_vld & de_prev_q & ~de;
        vs_fall    = pix_vld & vs_prev_q & ~vs;
        line_ok    = de_fall && (px_cnt_q >= MIN_W);
        width_eff  = line_ok ? px_cnt_q : width_q;
        lines_eff  = line_cnt_q;
        if (line_ok && line_cnt_q != '1)
            lines_eff = line_cnt_q + 1'b1;
        if (pix_vld) begin
            de_prev_d = de;
            vs_prev_d = vs;
            if (de)
                px_cnt_d = (px_cnt_q != '1) ? px_cnt_q + 1'b1 : px_cnt_q;
            else
                px_cnt_d = '0;
        end
        width_d     = width_eff;
        line_cnt_d  = vs_fall ? '0 : lines_eff;
        frame_match = (width_eff == ref_w_q) && (lines_eff == ref_l_q);
    end

    // Counter and previous-sync registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            de_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            px_cnt_q   <= '0;
            line_cnt_q <= '0;
            width_q    <= '0;
        end else begin
            de_prev_q  <= de_prev_d;
            vs_prev_q  <= vs_prev_d;
            px_cnt_q   <= px_cnt_d;
            line_cnt_q <= line_cnt_d;
            width_q    <= width_d;
        end
    end

    // Lock FSM: needs two consecutive matching, non-empty frames to lock.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_SEARCH;
            ref_w_q  <= '0;
            ref_l_q  <= '0;
            h_act_q  <= '0;
            v_act_q  <= '0;
            locked_q <= 1'b0;
        end else if (vs_fall) begin
            case (state_q)
                ST_SEARCH: state_q <= ST_MEASURE;
                ST_MEASURE: begin
                    ref_w_q <= width_eff;
                    ref_l_q <= lines_eff;
                    h_act_q <= width_eff;
                    v_act_q <= lines_eff;
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    h_act_q <= width_eff;
                    v_act_q <= lines_eff;
                    if (frame_match && lines_eff != '0) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        ref_w_q <= width_eff;
                        ref_l_q <= lines_eff;
                    end
                end
                ST_LOCKED: begin
                    h_act_q <= width_eff;
                    v_act_q <= lines_eff;
                    if (!frame_match) begin
                        state_q  <= ST_SEARCH;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end else if (state_q == ST_LOCKED && line_ok && px_cnt_q != ref_w_q) begin
            // A single off-width line while locked drops lock immediately.
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
        end
    end

    assign h_active = h_act_q;
    assign v_active = v_act_q;
    assign locked   = locked_q;

endmodule

// File: rtl/adv_ddr_rx.sv
// DDR half-pixel receiver: registers the pins, pairs low/high halves into
// 24-bpp pixels with their syncs, flags phase errors and measures video.
module adv_ddr_rx
    import adv_ddr_pkg::*;
#(
    parameter int H_W       = H_W_DEF,
    parameter int V_W       = V_W_DEF,
    parameter int MIN_H_ACT = MIN_H_ACT_DEF
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              ddr_clk_pixel,
    input  logic              ddr_de,
    input  logic              ddr_hsync,
    input  logic              ddr_vsync,
    input  logic [HALF_W-1:0] ddr_data,
    output logic              pixel_valid,
    output logic [23:0]       data_out,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic [H_W-1:0]    h_active,
    output logic [V_W-1:0]    v_active,
    output logic              locked,
    output logic              phase_err
);

    // Registered pin copies; in_vld_q keeps the reset value of the pin
    // register from being mistaken for a real phase-0 sample.
    logic              in_vld_q;
    logic              ph_q;
    logic              de_in_q;
    logic              hs_in_q;
    logic              vs_in_q;
    logic [HALF_W-1:0] dat_in_q;

    logic              pend_q, pend_d;
    logic [HALF_W-1:0] lo_q, lo_d;
    logic              hde_q, hde_d;
    logic              hhs_q, hhs_d;
    logic              hvs_q, hvs_d;
    logic              vld_q, vld_d;
    logic [23:0]       dout_q, dout_d;
    logic              deo_q, deo_d;
    logic              hso_q, hso_d;
    logic              vso_q, vso_d;
    logic              perr_q, perr_d;

    // Single input register stage on all DDR pins.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            in_vld_q <= 1'b0;
            ph_q     <= 1'b0;
            de_in_q  <= 1'b0;
            hs_in_q  <= 1'b0;
            vs_in_q  <= 1'b0;
            dat_in_q <= '0;
        end else begin
            in_vld_q <= 1'b1;
            ph_q     <= ddr_clk_pixel;
            de_in_q  <= ddr_de;
            hs_in_q  <= ddr_hsync;
            vs_in_q  <= ddr_vsync;
            dat_in_q <= ddr_data;
        end
    end

    // Phase assembly: phase 1 holds the low half and syncs, the next phase 0
    // completes the pixel. Out-of-order halves set the sticky error.
    always_comb begin
        pend_d = pend_q;
        lo_d   = lo_q;
        hde_d  = hde_q;
        hhs_d  = hhs_q;
        hvs_d  = hvs_q;
        vld_d  = 1'b0;
        dout_d = dout_q;
        deo_d  = deo_q;
        hso_d  = hso_q;
        vso_d  = vso_q;
        perr_d = perr_q;
        if (in_vld_q) begin
            if (ph_q) begin
                if (pend_q)
                    perr_d = 1'b1;
                lo_d   = dat_in_q;
                hde_d  = de_in_q;
                hhs_d  = hs_in_q;
                hvs_d  = vs_in_q;
                pend_d = 1'b1;
            end else if (pend_q) begin
                vld_d  = 1'b1;
                dout_d = {dat_in_q, lo_q};
                deo_d  = hde_q;
                hso_d  = hhs_q;
                vso_d  = hvs_q;
                pend_d = 1'b0;
            end else begin
                perr_d = 1'b1;
            end
        end
    end

    // Assembly state and registered pixel outputs.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
            lo_q   <= '0;
            hde_q  <= 1'b0;
            hhs_q  <= 1'b0;
            hvs_q  <= 1'b0;
            vld_q  <= 1'b0;
            dout_q <= '0;
            deo_q  <= 1'b0;
            hso_q  <= 1'b0;
            vso_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            lo_q   <= lo_d;
            hde_q  <= hde_d;
            hhs_q  <= hhs_d;
            hvs_q  <= hvs_d;
            vld_q  <= vld_d;
            dout_q <= dout_d;
            deo_q  <= deo_d;
            hso_q  <= hso_d;
            vso_q  <= vso_d;
            perr_q <= perr_d;
        end
    end

    assign pixel_valid = vld_q;
    assign data_out    = dout_q;
    assign de_out      = deo_q;
    assign hsync_out   = hso_q;
    assign vsync_out   = vso_q;
    assign phase_err   = perr_q;

    adv_ddr_rx_meas #(
        .H_W       (H_W),
        .V_W       (V_W),
        .MIN_H_ACT (MIN_H_ACT)
    ) u_meas (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .pix_vld  (vld_q),
        .de       (deo_q),
        .vs       (vso_q),
        .h_active (h_active),
        .v_active (v_active),
        .locked   (locked)
    );

endmodule

// File: tb/tb_adv_ddr_rx.sv
// Randomized bench for adv_ddr_rx with a pixel-pairing model and a
// frame-history model of measurement and lock.
module tb_adv_ddr_rx;
    import adv_ddr_pkg::*;

    localparam int H_W   = 12;
    localparam int V_W   = 11;
    localparam int MIN_H = 16;

    logic           clk_in = 1'b0;
    logic           reset_n = 1'b0;
    logic           ddr_clk_pixel = 1'b0;
    logic           ddr_de = 1'b0;
    logic           ddr_hsync = 1'b0;
    logic           ddr_vsync = 1'b0;
    logic [11:0]    ddr_data = '0;
    logic           pixel_valid;
    logic [23:0]    data_out;
    logic           de_out, hsync_out, vsync_out;
    logic [H_W-1:0] h_active;
    logic [V_W-1:0] v_active;
    logic           locked;
    logic           phase_err;

    adv_ddr_rx #(.H_W(H_W), .V_W(V_W), .MIN_H_ACT(MIN_H)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .ddr_clk_pixel(ddr_clk_pixel),
        .ddr_de(ddr_de), .ddr_hsync(ddr_hsync), .ddr_vsync(ddr_vsync),
        .ddr_data(ddr_data), .pixel_valid(pixel_valid), .data_out(data_out),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .h_active(h_active), .v_active(v_active), .locked(locked),
        .phase_err(phase_err)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_fail = 0;

    // Pairing model: what the outputs must show after the next edge.
    bit          m_pend, m_perr, m_hde, m_hhs, m_hvs;
    logic [11:0] m_lo;
    bit          e_vld, e_de, e_hs, e_vs, e_perr;
    logic [23:0] e_data;
    bit          obs_prev;
    int          obs_strobes;

    // Frame-history model: nb = frame boundaries seen since the last
    // restart of lock acquisition.
    int nb, lines, last_w, prev_w, prev_l, e_h, e_v;
    bit e_lock;

    task automatic model_reset();
        m_pend = 0; m_perr = 0; m_hde = 0; m_hhs = 0; m_hvs = 0; m_lo = '0;
        e_vld = 0; e_de = 0; e_hs = 0; e_vs = 0; e_perr = 0; e_data = '0;
        obs_prev = 0;
        nb = 0; lines = 0; last_w = 0; prev_w = 0; prev_l = 0;
        e_h = 0; e_v = 0; e_lock = 0;
    endtask

    task automatic model_line(input int w);
        if (w >= MIN_H) begin
            last_w = w;
            lines++;
            if (e_lock && w != prev_w) begin
                e_lock = 0;
                nb = 0;
            end
        end
    endtask

    task automatic model_boundary();
        nb++;
        if (nb >= 2) begin
            e_h = last_w;
            e_v = lines;
            if (e_lock) begin
                if (last_w != prev_w || lines != prev_l) begin
                    e_lock = 0;
                    nb = 0;
                end
            end else if (nb >= 3 && last_w == prev_w && lines == prev_l && lines != 0) begin
                e_lock = 1;
            end
            prev_w = last_w;
            prev_l = lines;
        end
        lines = 0;
    endtask

    // One half-pixel per clock; checks the outputs produced by the previous half.
    task automatic drive_half(input bit ph, input logic [11:0] d, input bit de, input bit hs, input bit vs);
        logic [28:0] act, exp;
        @(negedge clk_in);
        ddr_clk_pixel = ph; ddr_data = d; ddr_de = de; ddr_hsync = hs; ddr_vsync = vs;
        @(posedge clk_in);
        #1;
        act = {pixel_valid, data_out, de_out, hsync_out, vsync_out, phase_err};
        exp = {e_vld, e_data, e_de, e_hs, e_vs, e_perr};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL pixel_out: got {vld,data,de,hs,vs,perr}=%h expected %h at %0t", act, exp, $time);
        end
        n_chk++;
        if (pixel_valid === 1'b1 && obs_prev) begin
            n_fail++;
            $display("FAIL strobe_spacing: pixel_valid high on consecutive cycles at %0t", $time);
        end
        if (pixel_valid === 1'b1) obs_strobes++;
        obs_prev = (pixel_valid === 1'b1);
        e_vld = 0;
        if (ph) begin
            if (m_pend) m_perr = 1;
            m_lo = d; m_hde = de; m_hhs = hs; m_hvs = vs; m_pend = 1;
        end else if (m_pend) begin
            e_vld = 1; e_data = {d, m_lo}; e_de = m_hde; e_hs = m_hhs; e_vs = m_hvs;
            m_pend = 0;
        end else begin
            m_perr = 1;
        end
        e_perr = m_perr;
    endtask

    task automatic send_pixel(input logic [23:0] d, input bit de, input bit hs, input bit vs);
        drive_half(1'b1, d[11:0], de, hs, vs);
        // Syncs in the high half are don't-care; randomize them.
        drive_half(1'b0, d[23:12], 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic send_frame(input int w, input int nl, input int bad, input int bad_w);
        int wl;
        for (int l = 0; l < nl; l++) begin
            wl = (l == bad) ? bad_w : w;
            for (int p = 0; p < wl; p++) send_pixel(24'($urandom), 1, 0, 0);
            model_line(wl);
            repeat (3) send_pixel(24'($urandom), 0, 1, 0);
        end
        repeat (2) send_pixel(24'($urandom), 0, 0, 1);
        send_pixel(24'($urandom), 0, 0, 0);
        model_boundary();
        send_pixel(24'($urandom), 0, 0, 0);
        n_chk++;
        if (h_active !== e_h[H_W-1:0]) begin
            n_fail++;
            $display("FAIL frame_h_active: got %0d expected %0d", h_active, e_h);
        end
        n_chk++;
        if (v_active !== e_v[V_W-1:0]) begin
            n_fail++;
            $display("FAIL frame_v_active: got %0d expected %0d", v_active, e_v);
        end
        n_chk++;
        if (locked !== e_lock) begin
            n_fail++;
            $display("FAIL frame_locked: got %b expected %b", locked, e_lock);
        end
    endtask

    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        ddr_clk_pixel = 0; ddr_de = 0; ddr_hsync = 0; ddr_vsync = 0; ddr_data = '0;
        @(posedge clk_in);
        @(posedge clk_in);
        #2 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_in);
        #1;
        n_chk++;
        if ({pixel_valid, data_out, de_out, hsync_out, vsync_out, h_active, v_active, locked, phase_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outputs not all zero (data=%h h=%0d v=%0d lock=%b perr=%b)",
                     data_out, h_active, v_active, locked, phase_err);
        end
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_assembly();
        int s0;
        drive_half(1'b1, 12'hABC, 1, 0, 0);
        drive_half(1'b0, 12'h123, 0, 0, 0);
        n_chk++;
        if (pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL asm_latency: pixel_valid=%b one cycle after high half, expected 0", pixel_valid);
        end
        drive_half(1'b1, 12'h456, 1, 0, 0);
        n_chk++;
        if (pixel_valid !== 1'b1 || data_out !== 24'h123ABC || de_out !== 1'b1) begin
            n_fail++;
            $display("FAIL asm_first_pixel: vld=%b data=%h de=%b expected 1 123abc 1", pixel_valid, data_out, de_out);
        end
        drive_half(1'b0, 12'h789, 0, 0, 0);
        s0 = obs_strobes;
        for (int i = 0; i < 16; i++) send_pixel(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        send_pixel(24'h0, 0, 0, 0);
        n_chk++;
        if (obs_strobes - s0 != 17) begin
            n_fail++;
            $display("FAIL asm_strobe_rate: got %0d strobes expected 17", obs_strobes - s0);
        end
        n_chk++;
        if (phase_err !== 1'b0) begin
            n_fail++;
            $display("FAIL asm_no_phase_err: phase_err=%b expected 0", phase_err);
        end
    endtask

    task automatic test_phase_err();
        drive_half(1'b1, 12'h111, 1, 0, 0);
        drive_half(1'b0, 12'h222, 0, 0, 0);
        drive_half(1'b0, 12'h333, 0, 0, 0);   // orphan high half
        drive_half(1'b1, 12'h444, 1, 1, 0);
        n_chk++;
        if (phase_err !== 1'b1 || pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_orphan: perr=%b vld=%b expected 1 0", phase_err, pixel_valid);
        end
        drive_half(1'b0, 12'h555, 0, 0, 0);
        drive_half(1'b1, 12'h666, 0, 0, 1);
        n_chk++;
        if (pixel_valid !== 1'b1 || data_out !== 24'h555444 || hsync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_realign: vld=%b data=%h hs=%b expected 1 555444 1", pixel_valid, data_out, hsync_out);
        end
        drive_half(1'b1, 12'h777, 1, 0, 0);   // two lows in a row: overwrite
        drive_half(1'b0, 12'h888, 0, 0, 0);
        drive_half(1'b1, 12'h999, 0, 0, 0);
        n_chk++;
        if (pixel_valid !== 1'b1 || data_out !== 24'h888777) begin
            n_fail++;
            $display("FAIL perr_overwrite: vld=%b data=%h expected 1 888777", pixel_valid, data_out);
        end
        drive_half(1'b0, 12'h000, 0, 0, 0);
        for (int i = 0; i < 6; i++) send_pixel(24'($urandom), 1, 0, 0);
        n_chk++;
        if (phase_err !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_sticky: phase_err=%b expected 1", phase_err);
        end
    endtask

    task automatic test_frames(output int w);
        int nl;
        w  = $urandom_range(20, 60);
        nl = $urandom_range(3, 6);
        repeat (3) send_frame(w, nl, -1, 0);
        n_chk++;
        if (locked !== 1'b1 || h_active !== H_W'(w) || v_active !== V_W'(nl)) begin
            n_fail++;
            $display("FAIL frames_lock: lock=%b h=%0d v=%0d expected 1 %0d %0d", locked, h_active, v_active, w, nl);
        end
    endtask

    task automatic test_relock(input int w);
        int nl;
        nl = prev_l;
        send_frame(w, nl, 1, w - 1);
        n_chk++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_drop: locked=%b after short line, expected 0", locked);
        end
        send_frame(w, nl, -1, 0);
        send_frame(w, nl, -1, 0);
        n_chk++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock_regain: locked=%b expected 1", locked);
        end
    endtask

    task automatic test_720p_width();
        repeat (3) send_frame(H_ACT_720P, 2, -1, 0);
        n_chk++;
        if (h_active !== H_W'(H_ACT_720P) || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL width_720p: h=%0d lock=%b expected %0d 1", h_active, locked, H_ACT_720P);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) send_pixel(24'($urandom), 1, 0, 0);
        drive_half(1'b1, 12'hFED, 1, 0, 0);   // leave a half pending
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({pixel_valid, data_out, de_out, hsync_out, vsync_out, h_active, v_active, locked, phase_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: outputs not zero during reset (data=%h h=%0d lock=%b)", data_out, h_active, locked);
        end
        @(posedge clk_in);
        @(posedge clk_in);
        #2 reset_n = 1'b1;
        model_reset();
        drive_half(1'b0, 12'hBAD, 0, 0, 0);
        drive_half(1'b1, 12'h0A5, 1, 0, 0);
        n_chk++;
        if (pixel_valid !== 1'b0 || phase_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fresh_pair: vld=%b perr=%b expected 0 1", pixel_valid, phase_err);
        end
        drive_half(1'b0, 12'h5A0, 0, 0, 0);
        drive_half(1'b1, 12'h000, 0, 0, 0);
        n_chk++;
        if (pixel_valid !== 1'b1 || data_out !== 24'h5A00A5) begin
            n_fail++;
            $display("FAIL reset_first_pixel: vld=%b data=%h expected 1 5a00a5", pixel_valid, data_out);
        end
        drive_half(1'b0, 12'h000, 0, 0, 0);
    endtask

    task automatic test_runt();
        pulse_reset();
        repeat (3) send_frame(8, 4, -1, 0);
        n_chk++;
        if (v_active !== '0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL runt_lines: v=%0d lock=%b expected 0 0", v_active, locked);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        model_reset();
        obs_strobes = 0;
        test_reset();
        test_assembly();
        test_phase_err();
        pulse_reset();
        test_frames(w);
        test_relock(w);
        test_720p_width();
        test_reset_mid();
        test_runt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
